dvi_timing_monitor: RTL and testbench

Receive-side counterpart to the DVI Pmod output path. It samples the hsync/vsync/de/RGB stream on the pixel clock and recovers pixel coordinates. It checks the stream against 640x480@60 timing, reports a lock status and error pulses, and produces a per-frame pixel checksum. It is used in simulation and on-board loopback to verify the sync generator and the pixel painting logic.

---
 rtl/dvi_pkg.sv | 23 ++
 rtl/dvi_edge_detect.sv | 26 ++
 rtl/dvi_timing_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_dvi_timing_monitor.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// dvi_pkg: shared 640x480@60 timing constants and monitor state type.
// Imported by the DVI timing monitor and its edge detector.
package dvi_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } mon_state_t;

endpackage

// File: rtl/dvi_edge_detect.sv
// dvi_edge_detect: registered rise/fall pulse generator.
// Ports: clk_i, reset_i, d_i in; level_o (d_i delayed), rise_o, fall_o out.
module dvi_edge_detect
    import dvi_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            level_o <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            level_o <= d_i;
            rise_o  <= d_i & ~level_o;
            fall_o  <= ~d_i & level_o;
        end
    end

endmodule

// File: rtl/dvi_timing_monitor.sv
// dvi_timing_monitor: recovers pixel coordinates from a DVI sync/de/RGB
// stream, checks line/frame timing, tracks lock, errors and frame checksum.
// Ports: clk_i, reset_i, hsync_i, vsync_i, de_i, r_i/g_i/b_i in;
// x_o, y_o, pixel_valid_o, frame_start_o, locked_o, line_err_o,
// frame_err_o, err_count_o, frame_sum_o, frame_sum_valid_o out.
module dvi_timing_monitor
    import dvi_pkg::*;
#(
    parameter int h_active_p        = H_ACTIVE,
    parameter int h_total_p         = H_TOTAL,
    parameter int v_active_p        = V_ACTIVE,
    parameter bit sync_active_low_p = 1'b1,
    parameter int lock_frames_p     = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        de_i,
    input  logic [3:0]  r_i,
    input  logic [3:0]  g_i,
    input  logic [3:0]  b_i,
    output logic [9:0]  x_o,
    output logic [9:0]  y_o,
    output logic        pixel_valid_o,
    output logic        frame_start_o,
    output logic        locked_o,
    output logic        line_err_o,
    output logic        frame_err_o,
    output logic [7:0]  err_count_o,
    output logic [15:0] frame_sum_o,
    output logic        frame_sum_valid_o
);

    localparam logic [10:0] HACT  = 11'(h_active_p);
    localparam logic [11:0] HTOT  = 12'(h_total_p);
    localparam logic [9:0]  VACT  = 10'(v_active_p);
    localparam logic [7:0]  LOCKN = 8'(lock_frames_p);
    // Raw sync level meaning "not asserted"
    localparam logic        IDLE  = sync_active_low_p;

    logic        hs_q, vs_q, de_q;
    logic [11:0] rgb_q, rgb_d;
    logic        hs_n, vs_n, hs_d;
    logic        hs_edge_unused;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hs_q  <= IDLE;
            vs_q  <= IDLE;
            de_q  <= 1'b0;
            rgb_q <= '0;
            rgb_d <= '0;
            hs_d  <= 1'b0;
        end else begin
            hs_q  <= hsync_i;
            vs_q  <= vsync_i;
            de_q  <= de_i;
            rgb_q <= {r_i, g_i, b_i};
            // aligned with the de level out of the edge detector
            rgb_d <= rgb_q;
            hs_d  <= hs_n;
        end
    end

    assign hs_n = hs_q ^ sync_active_low_p;
    assign vs_n = vs_q ^ sync_active_low_p;
    // hsync is observed for edges only; it feeds no check
    assign hs_edge_unused = hs_n ^ hs_d;

    logic de_lvl, de_rise, de_fall;
    logic vs_lvl_unused, vs_rise, vs_fall_unused;

    dvi_edge_detect u_de_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (de_q),
        .level_o (de_lvl),
        .rise_o  (de_rise),
        .fall_o  (de_fall)
    );

    dvi_edge_detect u_vs_edge (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (vs_n),
        .level_o (vs_lvl_unused),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall_unused)
    );

    mon_state_t  state;
    logic [7:0]  good;
    logic        dirty;
    logic [10:0] hlen;
    logic [11:0] spacing;
    logic        sp_valid;
    logic [9:0]  lines;
    logic [15:0] acc;
    logic        active, line_bad, frame_bad, clean;

    always_comb begin
        active    = (state != SEARCH);
        line_bad  = active &&
                    ((de_fall && hlen != HACT) ||
                     (de_rise && sp_valid && spacing != HTOT));
        frame_bad = active && vs_rise && (lines != VACT);
        clean     = !dirty && !line_bad && !frame_bad;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hlen              <= '0;
            spacing           <= '0;
            sp_valid          <= 1'b0;
            lines             <= '0;
            acc               <= '0;
            x_o               <= '0;
            y_o               <= '0;
            pixel_valid_o     <= 1'b0;
            frame_start_o     <= 1'b0;
            line_err_o        <= 1'b0;
            frame_err_o       <= 1'b0;
            err_count_o       <= '0;
            frame_sum_o       <= '0;
            frame_sum_valid_o <= 1'b0;
        end else begin
            if (de_rise)
                hlen <= 11'd1;
            else if (de_lvl && hlen != '1)
                hlen <= hlen + 11'd1;

            if (de_rise)
                spacing <= 12'd1;
            else if (spacing != '1)
                spacing <= spacing + 12'd1;

            if (vs_rise)
                sp_valid <= 1'b0;
            else if (de_rise)
                sp_valid <= 1'b1;

            if (vs_rise)
                lines <= {9'd0, de_rise};
            else if (de_rise && lines != '1)
                lines <= lines + 10'd1;

            if (de_rise) begin
                x_o <= '0;
                y_o <= lines;
            end else if (de_lvl && x_o != '1) begin
                x_o <= x_o + 10'd1;
            end
            pixel_valid_o <= de_lvl;

            if (vs_rise)
                acc <= '0;
            else if (de_lvl)
                acc <= acc + {4'd0, rgb_d};

            frame_start_o     <= vs_rise;
            line_err_o        <= line_bad;
            frame_err_o       <= frame_bad;
            frame_sum_valid_o <= vs_rise && active;
            if (vs_rise && active)
                frame_sum_o <= acc;

            if ((line_bad || frame_bad) && err_count_o != 8'hFF)
                err_count_o <= err_count_o + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= SEARCH;
            good     <= '0;
            dirty    <= 1'b0;
            locked_o <= 1'b0;
        end else begin
            locked_o <= (state == LOCKED);
            // a line error marks the open frame as not clean
            if (vs_rise)
                dirty <= 1'b0;
            else if (line_bad)
                dirty <= 1'b1;
            unique case (state)
                SEARCH: begin
                    if (vs_rise) begin
                        state <= MEASURE;
                        good  <= '0;
                    end
                end
                MEASURE: begin
                    if (vs_rise) begin
                        if (!clean) begin
                            good <= '0;
                        end else if (good + 8'd1 >= LOCKN) begin
                            state <= LOCKED;
                            good  <= '0;
                        end else begin
                            good <= good + 8'd1;
                        end
                    end else if (line_bad) begin
                        good <= '0;
                    end
                end
                LOCKED: begin
                    if (line_bad || frame_bad) begin
                        state <= MEASURE;
                        good  <= '0;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_dvi_timing_monitor.sv
// tb_dvi_timing_monitor: directed bench for dvi_timing_monitor using a
// reduced 16x8 raster (24-cycle lines, 11-line frames).
module tb_dvi_timing_monitor;

    localparam int HA = 16;
    localparam int HT = 24;
    localparam int VA = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic        de = 1'b0;
    logic [3:0]  r = '0, g = '0, b = '0;
    logic [9:0]  x_o, y_o;
    logic        pixel_valid_o, frame_start_o, locked_o;
    logic        line_err_o, frame_err_o, frame_sum_valid_o;
    logic [7:0]  err_count_o;
    logic [15:0] frame_sum_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    dvi_timing_monitor #(
        .h_active_p        (HA),
        .h_total_p         (HT),
        .v_active_p        (VA),
        .sync_active_low_p (1'b1),
        .lock_frames_p     (2)
    ) dut (
        .clk_i             (clk),
        .reset_i           (rst),
        .hsync_i           (hsync),
        .vsync_i           (vsync),
        .de_i              (de),
        .r_i               (r),
        .g_i               (g),
        .b_i               (b),
        .x_o               (x_o),
        .y_o               (y_o),
        .pixel_valid_o     (pixel_valid_o),
        .frame_start_o     (frame_start_o),
        .locked_o          (locked_o),
        .line_err_o        (line_err_o),
        .frame_err_o       (frame_err_o),
        .err_count_o       (err_count_o),
        .frame_sum_o       (frame_sum_o),
        .frame_sum_valid_o (frame_sum_valid_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_fs = 0, n_le = 0, n_fe = 0, n_sv = 0;
    int fs_cyc = 0, le_cyc = 0, fe_cyc = 0, sv_cyc = 0, lock_cyc = 0;
    int fp_cyc = 0, lp_cyc = 0;
    logic [15:0] last_sum = '0;
    logic [9:0]  fp_x = '1, fp_y = '1, lp_x = '0, lp_y = '0;
    logic        pv_prev = 1'b0, lk_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_start_o) begin n_fs++; fs_cyc = cyc; end
            if (line_err_o) begin n_le++; le_cyc = cyc; end
            if (frame_err_o) begin n_fe++; fe_cyc = cyc; end
            if (frame_sum_valid_o) begin
                n_sv++; sv_cyc = cyc; last_sum = frame_sum_o;
            end
            if (locked_o && !lk_prev) lock_cyc = cyc;
            if (pixel_valid_o && !pv_prev && y_o == 10'd0) begin
                fp_cyc = cyc; fp_x = x_o; fp_y = y_o;
            end
            if (pixel_valid_o && y_o == 10'(VA - 1)) begin
                lp_cyc = cyc; lp_x = x_o; lp_y = y_o;
            end
        end
        pv_prev = pixel_valid_o;
        lk_prev = locked_o;
    end

    int ls_idx = 0, vs_idx = 0, first_idx = 0, last_idx = 0, bad_idx = 0;

    task automatic drive(input logic hs, input logic vs, input logic d,
                         input logic [11:0] rgb);
        @(negedge clk);
        hsync = hs; vsync = vs; de = d;
        r = rgb[11:8]; g = rgb[7:4]; b = rgb[3:0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic send_line(input int dlen, input logic vs_on,
                             input logic [11:0] rgb);
        for (int c = 0; c < HT; c++) begin
            drive(!(c >= 18 && c < 21), !vs_on, c < dlen, rgb);
            if (c == 0) ls_idx = cyc + 1;
        end
    endtask

    // kind: 0 clean, 1 short de on bad_line, 2 de missing on bad_line,
    // 3 stop before bad_line
    task automatic send_frame(input int kind, input int bad_line,
                              input logic [11:0] rgb);
        send_line(0, 1'b1, rgb);
        vs_idx = ls_idx;
        send_line(0, 1'b0, rgb);
        for (int l = 0; l < VA; l++) begin
            int len;
            if (kind == 3 && l == bad_line) return;
            len = HA;
            if (kind == 1 && l == bad_line) len = HA - 1;
            if (kind == 2 && l == bad_line) len = 0;
            send_line(len, 1'b0, rgb);
            if (l == 0) first_idx = ls_idx;
            if (l == VA - 1) last_idx = ls_idx + HA - 1;
            if (kind == 1 && l == bad_line) bad_idx = ls_idx + HA - 1;
            if (kind == 2 && l == bad_line + 1) bad_idx = ls_idx;
        end
        send_line(0, 1'b0, rgb);
    endtask

    task automatic test_reset;
        idle(3);
        checks++;
        if (x_o !== 10'd0 || y_o !== 10'd0) begin
            errors++;
            $display("FAIL reset_xy got %0d/%0d want 0/0", x_o, y_o);
        end
        checks++;
        if ({pixel_valid_o, frame_start_o, locked_o, line_err_o,
             frame_err_o, frame_sum_valid_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0", {pixel_valid_o,
                     frame_start_o, locked_o, line_err_o, frame_err_o,
                     frame_sum_valid_o});
        end
        checks++;
        if (err_count_o !== 8'd0 || frame_sum_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%h want 0/0",
                     err_count_o, frame_sum_o);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_lock;
        for (int f = 0; f < 3; f++) send_frame(0, 0, 12'h111);
        checks++;
        if (n_fs != 3) begin
            errors++; $display("FAIL lock_fs_count got %0d want 3", n_fs);
        end
        checks++;
        if (fs_cyc != vs_idx + 2) begin
            errors++;
            $display("FAIL lock_fs_time got %0d want %0d", fs_cyc, vs_idx + 2);
        end
        checks++;
        if (lock_cyc != vs_idx + 3 || locked_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_rise got %0d/%b want %0d/1",
                     lock_cyc, locked_o, vs_idx + 3);
        end
        checks++;
        if (err_count_o !== 8'd0 || n_le != 0 || n_fe != 0) begin
            errors++;
            $display("FAIL lock_errs got %0d want 0", err_count_o);
        end
        checks++;
        if (n_sv != 2 || last_sum !== 16'h8880 || sv_cyc != fs_cyc) begin
            errors++;
            $display("FAIL lock_sum got %0d/%h want 2/8880", n_sv, last_sum);
        end
    endtask

    task automatic test_checksum;
        send_frame(0, 0, 12'h357);
        checks++;
        if (n_sv != 3 || last_sum !== 16'h8880) begin
            errors++;
            $display("FAIL sum_ones got %0d/%h want 3/8880", n_sv, last_sum);
        end
        send_frame(0, 0, 12'h111);
        checks++;
        if (last_sum !== 16'hAB80) begin
            errors++;
            $display("FAIL sum_357 got %h want ab80", last_sum);
        end
        checks++;
        if (sv_cyc != vs_idx + 2) begin
            errors++;
            $display("FAIL sum_time got %0d want %0d", sv_cyc, vs_idx + 2);
        end
    endtask

    task automatic test_coords;
        send_frame(0, 0, 12'h111);
        checks++;
        if (fp_x !== 10'd0 || fp_y !== 10'd0 || fp_cyc != first_idx + 2) begin
            errors++;
            $display("FAIL first_px got %0d/%0d@%0d want 0/0@%0d",
                     fp_x, fp_y, fp_cyc, first_idx + 2);
        end
        checks++;
        if (lp_x !== 10'(HA - 1) || lp_y !== 10'(VA - 1) ||
            lp_cyc != last_idx + 2) begin
            errors++;
            $display("FAIL last_px got %0d/%0d@%0d want %0d/%0d@%0d",
                     lp_x, lp_y, lp_cyc, HA - 1, VA - 1, last_idx + 2);
        end
    endtask

    task automatic test_short_de;
        int le0, fe0;
        le0 = n_le; fe0 = n_fe;
        send_frame(1, 3, 12'h111);
        checks++;
        if (n_le - le0 != 1 || le_cyc != bad_idx + 2) begin
            errors++;
            $display("FAIL short_le got %0d@%0d want 1@%0d",
                     n_le - le0, le_cyc, bad_idx + 2);
        end
        checks++;
        if (err_count_o !== 8'd1 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL short_cnt got %0d/%b want 1/0",
                     err_count_o, locked_o);
        end
        send_frame(0, 0, 12'h111);
        send_frame(0, 0, 12'h111);
        checks++;
        if (locked_o !== 1'b0) begin
            errors++; $display("FAIL short_early_lock got 1 want 0");
        end
        send_frame(0, 0, 12'h111);
        checks++;
        if (locked_o !== 1'b1 || lock_cyc != vs_idx + 3) begin
            errors++;
            $display("FAIL short_relock got %b@%0d want 1@%0d",
                     locked_o, lock_cyc, vs_idx + 3);
        end
        checks++;
        if (n_fe != fe0) begin
            errors++; $display("FAIL short_fe got %0d want 0", n_fe - fe0);
        end
    endtask

    task automatic test_missing_line;
        int le0, fe0;
        le0 = n_le; fe0 = n_fe;
        send_frame(2, 4, 12'h111);
        checks++;
        if (n_le - le0 != 1 || le_cyc != bad_idx + 2) begin
            errors++;
            $display("FAIL miss_le got %0d@%0d want 1@%0d",
                     n_le - le0, le_cyc, bad_idx + 2);
        end
        send_frame(0, 0, 12'h111);
        checks++;
        if (n_fe - fe0 != 1 || fe_cyc != vs_idx + 2) begin
            errors++;
            $display("FAIL miss_fe got %0d@%0d want 1@%0d",
                     n_fe - fe0, fe_cyc, vs_idx + 2);
        end
        checks++;
        if (err_count_o !== 8'd3 || locked_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_cnt got %0d/%b want 3/0", err_count_o, locked_o);
        end
    endtask

    task automatic test_reset_midframe;
        int fs0, sv0, le0;
        send_frame(0, 0, 12'h111);
        send_frame(0, 0, 12'h111);
        checks++;
        if (locked_o !== 1'b1) begin
            errors++; $display("FAIL mid_prelock got 0 want 1");
        end
        send_frame(3, 4, 12'h111);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({x_o, y_o, pixel_valid_o, frame_start_o, locked_o, line_err_o,
             frame_err_o, err_count_o, frame_sum_o,
             frame_sum_valid_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset got %0d/%0d/%b/%0d/%h want all 0",
                     x_o, y_o, locked_o, err_count_o, frame_sum_o);
        end
        idle(2);
        rst = 1'b0;
        idle(4);
        fs0 = n_fs; sv0 = n_sv; le0 = n_le;
        send_line(0, 1'b1, 12'h111);
        send_line(0, 1'b0, 12'h111);
        checks++;
        if (n_fs - fs0 != 1 || n_sv != sv0) begin
            errors++;
            $display("FAIL mid_first_vs got fs%0d sv%0d want fs1 sv0",
                     n_fs - fs0, n_sv - sv0);
        end
        for (int i = 0; i < 300; i++) send_line(5, 1'b0, 12'h111);
        checks++;
        if (err_count_o !== 8'd255 || n_le - le0 != 300) begin
            errors++;
            $display("FAIL sat_count got %0d/%0d want 255/300",
                     err_count_o, n_le - le0);
        end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_checksum;
        test_coords;
        test_short_de;
        test_missing_line;
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
